// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 BCM scan engine: FSM state codes,
// pixel channel field offsets and the bits_for width helper.
package hub75_pkg;

  // FSM state encoding shared by the driver and anything that observes it.
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_ADDR     = 4'd1;
  localparam logic [3:0] ST_LOAD     = 4'd2;
  localparam logic [3:0] ST_CLK_HI   = 4'd3;
  localparam logic [3:0] ST_CLK_LO   = 4'd4;
  localparam logic [3:0] ST_WAIT     = 4'd5;
  localparam logic [3:0] ST_BLANK    = 4'd6;
  localparam logic [3:0] ST_LATCH_HI = 4'd7;
  localparam logic [3:0] ST_LATCH_LO = 4'd8;
  localparam logic [3:0] ST_UNBLANK  = 4'd9;
  localparam logic [3:0] ST_DEAD     = 4'd10;

  // Channel field positions inside a pixel word, in units of COLOR_DEPTH.
  // The pixel is {r,g,b} with r in the most significant field.
  localparam int R_OFS = 2;
  localparam int G_OFS = 1;
  localparam int B_OFS = 0;

  // Number of bits needed to hold the value (at least 1).
  function automatic int bits_for(input int value);
    int width;
    width = 1;
    for (int i = 1; i < 31; i++) begin
      if ((value >> i) != 0) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// Show-time down-counter for binary-code modulation. Loading sets the count
// to BASE_TICKS<<plane; it then decrements once per cycle until it reaches 0.
module hub75_bcm_timer
  import hub75_pkg::*;
#(
  parameter int BASE_TICKS  = 8,
  parameter int COLOR_DEPTH = 4,
  parameter int PLANE_BITS  = 2,
  parameter int CNT_BITS    = 7
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_load,
  input  logic [PLANE_BITS-1:0] i_plane,
  output logic                  o_zero
);

  logic [CNT_BITS-1:0] count;

  // Load has priority; otherwise count down to zero and stay there.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // values from before the clock edge, independent of statement order.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      count <= '0;
    end else if (i_load) begin
      count <= CNT_BITS'(BASE_TICKS << i_plane);
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign o_zero = (count == '0);

endmodule

// File: rtl/hub75_bcm_driver.sv
// HUB75 panel scan engine with binary-code-modulation colour depth.
// Fetches both panel halves from a synchronous-read framebuffer, shifts one
// bit-plane per row, latches it and keeps it lit for BASE_TICKS<<plane cycles
// while the next plane is shifted in underneath.
// Optional build macro: HUB75_DEADTIME_EN adds DEADTIME blank cycles after
// every latch/address change to suppress ghosting.
module hub75_bcm_driver
  import hub75_pkg::*;
#(
  parameter  int COLS        = 64,
  parameter  int ROWS        = 64,
  parameter  int COLOR_DEPTH = 4,
  parameter  int BASE_TICKS  = 8,
  parameter  int DEADTIME    = 2,
  localparam int ADDR_BITS   = bits_for(ROWS / 2 - 1),
  localparam int COL_BITS    = bits_for(COLS - 1),
  localparam int PIX_BITS    = 3 * COLOR_DEPTH
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_enable,
  output logic [ADDR_BITS+COL_BITS-1:0] o_fb_addr,
  input  logic [PIX_BITS-1:0]           i_fb_data_0,
  input  logic [PIX_BITS-1:0]           i_fb_data_1,
  output logic                          o_clock,
  output logic                          o_latch,
  output logic                          o_blank,
  output logic [2:0]                    o_rgb_0,
  output logic [2:0]                    o_rgb_1,
  output logic [4:0]                    o_address,
  output logic                          o_frame_done
);

  localparam int PLANE_BITS = bits_for(COLOR_DEPTH - 1);
  localparam int CNT_BITS   = bits_for(BASE_TICKS << (COLOR_DEPTH - 1));

  localparam logic [ADDR_BITS-1:0]  LAST_ROW   = ADDR_BITS'(ROWS / 2 - 1);
  localparam logic [COL_BITS-1:0]   LAST_COL   = COL_BITS'(COLS - 1);
  localparam logic [PLANE_BITS-1:0] LAST_PLANE = PLANE_BITS'(COLOR_DEPTH - 1);

  logic [3:0]            state;
  logic [3:0]            next_state;
  logic [ADDR_BITS-1:0]  row;
  logic [COL_BITS-1:0]   col;
  logic [PLANE_BITS-1:0] plane;
  logic                  show_zero;
  logic                  dead_done;

  // Both halves share one address; the RAM answers one cycle later.
  assign o_fb_addr = {row, col};

  // Select the current plane's bit from each channel, packed as {b,g,r}.
  function automatic logic [2:0] plane_bits(input logic [PIX_BITS-1:0]   pix,
                                            input logic [PLANE_BITS-1:0] pl);
    int idx;
    idx = int'(pl);
    return {pix[B_OFS*COLOR_DEPTH + idx],
            pix[G_OFS*COLOR_DEPTH + idx],
            pix[R_OFS*COLOR_DEPTH + idx]};
  endfunction

  hub75_bcm_timer #(
    .BASE_TICKS (BASE_TICKS),
    .COLOR_DEPTH(COLOR_DEPTH),
    .PLANE_BITS (PLANE_BITS),
    .CNT_BITS   (CNT_BITS)
  ) u_timer (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_load (state == ST_UNBLANK),
    .i_plane(plane),
    .o_zero (show_zero)
  );

`ifdef HUB75_DEADTIME_EN
  localparam int DEAD_BITS = bits_for(DEADTIME);

  logic [DEAD_BITS-1:0] dead_cnt;

  // Dead-time counter: armed on entry to DEAD, runs down to zero.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      dead_cnt <= '0;
    end else if (next_state == ST_DEAD && state != ST_DEAD) begin
      dead_cnt <= DEAD_BITS'(DEADTIME - 1);
    end else if (dead_cnt != '0) begin
      dead_cnt <= dead_cnt - 1'b1;
    end
  end

  assign dead_done = (dead_cnt == '0);
`else
  // Without the dead-time stage the parameter has no effect.
  logic unused_deadtime;
  assign unused_deadtime = (DEADTIME != 0);
  assign dead_done       = 1'b1;
`endif

  // Next-state decode for the shift/latch/show sequence.
  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (i_enable) next_state = ST_ADDR;
      ST_ADDR:     next_state = ST_LOAD;
      ST_LOAD:     next_state = ST_CLK_HI;
      ST_CLK_HI:   next_state = ST_CLK_LO;
      ST_CLK_LO:   next_state = (col == '0) ? ST_WAIT : ST_ADDR;
      ST_WAIT:     if (show_zero) next_state = ST_BLANK;
      ST_BLANK:    next_state = ST_LATCH_HI;
      ST_LATCH_HI: next_state = ST_LATCH_LO;
`ifdef HUB75_DEADTIME_EN
      ST_LATCH_LO: next_state = ST_DEAD;
      ST_DEAD:     if (dead_done) next_state = ST_UNBLANK;
`else
      ST_LATCH_LO: next_state = ST_UNBLANK;
`endif
      ST_UNBLANK:  next_state = i_enable ? ST_ADDR : ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  // State, counters and registered panel outputs. Outputs are decoded from
  // next_state so each one is valid during the state that owns it.
  // NOTE: reset is asynchronous, so a reset mid-shift or mid-show drops the
  // panel to dark and idle without waiting for a clock edge.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      row          <= '0;
      col          <= '0;
      plane        <= '0;
      o_clock      <= 1'b0;
      o_latch      <= 1'b0;
      o_blank      <= 1'b1;
      o_rgb_0      <= 3'b000;
      o_rgb_1      <= 3'b000;
      o_address    <= 5'd0;
      o_frame_done <= 1'b0;
    end else begin
      state        <= next_state;
      o_clock      <= (next_state == ST_CLK_HI);
      o_latch      <= (next_state == ST_LATCH_HI);
      o_frame_done <= (state == ST_UNBLANK) && (plane == LAST_PLANE) && (row == LAST_ROW);

      // Each new row/plane shift starts at the far column.
      if (next_state == ST_ADDR && (state == ST_IDLE || state == ST_UNBLANK)) begin
        col <= LAST_COL;
      end else if (state == ST_CLK_LO && col != '0) begin
        col <= col - 1'b1;
      end

      if (state == ST_LOAD) begin
        o_rgb_0 <= plane_bits(i_fb_data_0, plane);
        o_rgb_1 <= plane_bits(i_fb_data_1, plane);
      end

      if (next_state == ST_LATCH_HI) begin
        o_address <= 5'(row);
      end

      // The previous plane stays lit while shifting; dark only around the
      // latch, and in IDLE once the last plane's show time has run out.
      if (next_state == ST_BLANK) begin
        o_blank <= 1'b1;
      end else if (next_state == ST_UNBLANK) begin
        o_blank <= 1'b0;
      end else if (state == ST_IDLE && show_zero) begin
        o_blank <= 1'b1;
      end

      if (state == ST_UNBLANK) begin
        if (plane == LAST_PLANE) begin
          plane <= '0;
          row   <= (row == LAST_ROW) ? '0 : row + 1'b1;
        end else begin
          plane <= plane + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Self-checking bench for hub75_bcm_driver (4x4 panel, 2-bit colour).
// A framebuffer model feeds the DUT; expected shifts and latch addresses are
// queued up front and popped as o_clock / o_latch pulses are observed.
module tb_hub75_bcm_driver;

  localparam int COLS        = 4;
  localparam int ROWS        = 4;
  localparam int COLOR_DEPTH = 2;
  localparam int BASE_TICKS  = 32;
  localparam int DEADTIME    = 3;
`ifdef HUB75_DEADTIME_EN
  localparam int DT_EXTRA = DEADTIME;
`else
  localparam int DT_EXTRA = 0;
`endif

  typedef struct packed {
    logic [2:0] addr;
    logic [2:0] rgb0;
    logic [2:0] rgb1;
  } shift_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] fb_addr;
  logic [5:0] fb_q0, fb_q1;
  logic       p_clock, p_latch, p_blank, frame_done;
  logic [2:0] rgb0, rgb1;
  logic [4:0] address;

  logic [5:0] fb0 [8];
  logic [5:0] fb1 [8];

  shift_t shift_q [$];
  int     latch_q [$];
  int     blank_lows [$];
  int     dead_lens [$];

  int n_pass  = 0;
  int n_total = 0;
  int frame_cnt = 0;
  int latch_cnt = 0;
  int low_len   = 0;
  int dead_len  = 0;
  logic dead_run = 1'b0;
  logic mon_en   = 1'b0;
  logic clock_q  = 1'b0;
  logic latch_q1 = 1'b0;

  always #5 clk = ~clk;

  hub75_bcm_driver #(
    .COLS(COLS), .ROWS(ROWS), .COLOR_DEPTH(COLOR_DEPTH),
    .BASE_TICKS(BASE_TICKS), .DEADTIME(DEADTIME)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_enable(en),
    .o_fb_addr(fb_addr), .i_fb_data_0(fb_q0), .i_fb_data_1(fb_q1),
    .o_clock(p_clock), .o_latch(p_latch), .o_blank(p_blank),
    .o_rgb_0(rgb0), .o_rgb_1(rgb1), .o_address(address),
    .o_frame_done(frame_done)
  );

  // Synchronous-read framebuffer: data valid one cycle after the address.
  always @(posedge clk) begin
    fb_q0 <= fb0[fb_addr];
    fb_q1 <= fb1[fb_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    n_total++;
    assert (obs >= lo && obs <= hi) n_pass++;
    else $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
  endtask

  // Pixel {r,g,b} (r in MSBs) -> {b,g,r} bits of one plane.
  function automatic logic [2:0] exp_rgb(input logic [5:0] pix, input int p);
    return {pix[p], pix[COLOR_DEPTH + p], pix[2*COLOR_DEPTH + p]};
  endfunction

  task automatic push_plane(input int r, input int p);
    shift_t e;
    for (int c = COLS - 1; c >= 0; c--) begin
      e.addr = 3'(r * COLS + c);
      e.rgb0 = exp_rgb(fb0[e.addr], p);
      e.rgb1 = exp_rgb(fb1[e.addr], p);
      shift_q.push_back(e);
    end
    latch_q.push_back(r);
  endtask

  // Output monitor, sampled on the falling edge away from DUT updates.
  always @(negedge clk) begin
    clock_q  <= p_clock;
    latch_q1 <= p_latch;
    if (mon_en) begin
      if (p_clock && !clock_q) begin
        if (shift_q.size() == 0) begin
          check("unexpected_shift", 1, 0);
        end else begin
          shift_t e;
          e = shift_q.pop_front();
          check("fb_addr", fb_addr, e.addr);
          check("rgb_0", rgb0, e.rgb0);
          check("rgb_1", rgb1, e.rgb1);
        end
      end
      if (p_latch && !latch_q1) begin
        latch_cnt <= latch_cnt + 1;
        if (latch_q.size() == 0) check("unexpected_latch", 1, 0);
        else check("o_address", address, latch_q.pop_front());
      end
      if (frame_done) begin
        frame_cnt <= frame_cnt + 1;
        check("latches_per_frame", latch_cnt % 4, 0);
      end
      if (!p_blank) begin
        low_len <= low_len + 1;
      end else if (low_len != 0) begin
        blank_lows.push_back(low_len);
        low_len <= 0;
      end
      if (!p_latch && latch_q1) begin
        dead_run <= 1'b1;
        dead_len <= 1;
      end else if (dead_run) begin
        if (p_blank) begin
          dead_len <= dead_len + 1;
        end else begin
          dead_lens.push_back(dead_len);
          dead_run <= 1'b0;
        end
      end
    end
  end

  initial begin
    int cnt;
    int clocks_seen;
    rst = 1'b1;
    en  = 1'b0;
    for (int a = 0; a < 8; a++) begin
      fb0[a] = 6'($urandom);
      fb1[a] = 6'($urandom);
    end
    fb0[3] = 6'h3F;       // all ones on top, dark bottom
    fb1[3] = 6'h00;
    fb0[2] = 6'b10_01_00; // r=10 g=01 b=00
    fb1[6] = 6'b01_10_11;

    repeat (3) @(posedge clk);
    #1;
    check("rst_clock", p_clock, 0);
    check("rst_latch", p_latch, 0);
    check("rst_blank", p_blank, 1);
    check("rst_rgb_0", rgb0, 0);
    check("rst_rgb_1", rgb1, 0);
    check("rst_address", address, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_frame_done", frame_done, 0);

    // Reset asserted in the middle of a shift.
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    cnt = 0;
    while (!(p_clock && rgb0 != 0) && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("midshift_timeout", (cnt < 200), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_clock", p_clock, 0);
    check("mid_rst_blank", p_blank, 1);
    check("mid_rst_rgb_0", rgb0, 0);
    check("mid_rst_fb_addr", fb_addr, 0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("held_rst_blank", p_blank, 1);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Two full frames plus the first plane of a third.
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < ROWS / 2; r++)
        for (int p = 0; p < COLOR_DEPTH; p++)
          push_plane(r, p);
    push_plane(0, 0);
    mon_en = 1'b1;
    en     = 1'b1;

    cnt = 0;
    while (frame_cnt < 2 && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    check("frames_timeout", (cnt < 3000), 1);

    // Drop enable once the next plane has started shifting.
    cnt = 0;
    while (!p_clock && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("third_shift_timeout", (cnt < 50), 1);
    en = 1'b0;

    cnt = 0;
    while (latch_cnt < 9 && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    check("last_latch_timeout", (cnt < 500), 1);
    cnt = 0;
    while (p_blank && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("unblank_timeout", (cnt < 50), 1);
    cnt = 0;
    while (!p_blank && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("idle_blank_timeout", (cnt < 200), 1);

    clocks_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (p_clock || p_latch) clocks_seen++;
    end
    check("idle_quiet", clocks_seen, 0);
    check("idle_blank", p_blank, 1);
    check("shift_queue_drained", shift_q.size(), 0);
    check("latch_queue_drained", latch_q.size(), 0);
    check("frame_count", frame_cnt, 2);

    check("blank_low_count", blank_lows.size(), 9);
    for (int i = 0; i < blank_lows.size(); i++) begin
      check_range("blank_low_len", blank_lows[i],
                  BASE_TICKS << (i % 2), (BASE_TICKS << (i % 2)) + 4);
    end
    check("dead_count", dead_lens.size(), 9);
    for (int i = 0; i < 2 && i < dead_lens.size(); i++) begin
      check("blank_after_latch", dead_lens[i], 1 + DT_EXTRA);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
